// File: rtl/t05_huffman_decoder_if.sv
// Handshake bundle for the Huffman decoder.
//   control : start, max_index, num_chars  -> decoder; busy, done, error <- decoder
//   bits    : bit_in, bit_valid -> decoder; bit_ready <- decoder
//   htree   : htree_req, htree_index <- decoder; h_element, h_valid -> decoder
//   chars   : char_out, char_valid <- decoder; char_ready -> decoder
// slave is the decoder side, master is the surrounding system side.
interface t05_huffman_decoder_if;
    logic        start;
    logic [6:0]  max_index;
    logic [15:0] num_chars;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic        htree_req;
    logic [6:0]  htree_index;
    logic [63:0] h_element;
    logic        h_valid;
    logic [7:0]  char_out;
    logic        char_valid;
    logic        char_ready;
    logic        busy;
    logic        done;
    logic        error;

    modport slave (
        input  start, max_index, num_chars, bit_in, bit_valid, h_element, h_valid, char_ready,
        output bit_ready, htree_req, htree_index, char_out, char_valid, busy, done, error
    );

    modport master (
        output start, max_index, num_chars, bit_in, bit_valid, h_element, h_valid, char_ready,
        input  bit_ready, htree_req, htree_index, char_out, char_valid, busy, done, error
    );
endinterface

// File: rtl/t05_huffman_decoder.sv
// Serial Huffman decoder. Walks the htree in SRAM from the root, one coded
// bit per node (0 -> least1, 1 -> least2), and emits each character leaf
// over a valid/ready handshake.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : t05_huffman_decoder_if.slave (control, bit stream, htree read
//          port, character output, status)
// All outputs are registered; the FSM drives them on state transitions.
module t05_huffman_decoder (
    input  logic                      clk,
    input  logic                      rst,
    t05_huffman_decoder_if.slave      bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_NODE, S_WAIT_BIT, S_EMIT, S_DONE, S_ERROR
    } state_t;

    localparam logic [8:0] NULL_CHILD = 9'h180;

    state_t      state;
    logic [6:0]  root;
    logic [6:0]  node;       // current node index, doubles as htree_index
    logic [15:0] remaining;
    logic [7:0]  depth;      // one bit wider than the limit so overflow is visible
    logic [8:0]  least1;
    logic [8:0]  least2;
    logic        bit_ready_q;
    logic        htree_req_q;
    logic [7:0]  char_out_q;
    logic        char_valid_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;

    logic [8:0]  child;
    logic [7:0]  depth_nxt;

    assign child     = bus.bit_in ? least2 : least1;
    assign depth_nxt = depth + 8'd1;

    assign bus.bit_ready   = bit_ready_q;
    assign bus.htree_req   = htree_req_q;
    assign bus.htree_index = node;
    assign bus.char_out    = char_out_q;
    assign bus.char_valid  = char_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            root         <= '0;
            node         <= '0;
            remaining    <= '0;
            depth        <= '0;
            least1       <= '0;
            least2       <= '0;
            bit_ready_q  <= 1'b0;
            htree_req_q  <= 1'b0;
            char_out_q   <= '0;
            char_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (bus.start) begin
                        root      <= bus.max_index;
                        node      <= bus.max_index;
                        remaining <= bus.num_chars;
                        depth     <= '0;
                        error_q   <= 1'b0;
                        if (bus.num_chars == 16'd0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state       <= S_FETCH;
                            done_q      <= 1'b0;
                            busy_q      <= 1'b1;
                            htree_req_q <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    // request was raised on entry; this cycle is the one-cycle pulse
                    htree_req_q <= 1'b0;
                    state       <= S_WAIT_NODE;
                end
                S_WAIT_NODE: begin
                    if (bus.h_valid) begin
                        least1      <= bus.h_element[63:55];
                        least2      <= bus.h_element[54:46];
                        bit_ready_q <= 1'b1;
                        state       <= S_WAIT_BIT;
                    end
                end
                S_WAIT_BIT: begin
                    if (bus.bit_valid) begin
                        bit_ready_q <= 1'b0;
                        depth       <= depth_nxt;
                        // null test must precede the sum test: 9'h180 has bit 8 set
                        if (depth_nxt > 8'd127 || child == NULL_CHILD) begin
                            state   <= S_ERROR;
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (!child[8]) begin
                            char_out_q   <= child[7:0];
                            char_valid_q <= 1'b1;
                            state        <= S_EMIT;
                        end else begin
                            node        <= child[6:0];
                            htree_req_q <= 1'b1;
                            state       <= S_FETCH;
                        end
                    end
                end
                S_EMIT: begin
                    if (bus.char_ready) begin
                        char_valid_q <= 1'b0;
                        remaining    <= remaining - 16'd1;
                        depth        <= '0;
                        if (remaining == 16'd1) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            node        <= root;
                            htree_req_q <= 1'b1;
                            state       <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_t05_huffman_decoder.sv
// Self-checking bench for t05_huffman_decoder: table of decode runs with a
// character scoreboard, an SRAM responder with configurable latency, a bit
// source queue, plus hand-written reset sequences.
module tb_t05_huffman_decoder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    t05_huffman_decoder_if bus();
    t05_huffman_decoder dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [6:0]  root;
        logic [15:0] n;
        string       bits;
        string       exp;
        bit          exp_err;
        int          exp_cons;
        int          lat;
        int          stall_idx;
        int          stall_len;
        int          first_len;
    } tc_t;

    tc_t         tc [7];
    logic [63:0] mem [0:127];
    int checks = 0, failures = 0;
    bit  bq[$];
    byte expq[$];
    int consumed, accepted, reqs, br_seen, valid_seen, held, cyc;
    int first_req_cyc, first_valid_cyc, stall_left, stall_idx, cur_lat, pend;
    bit pend_act, hold_ready;

    function automatic tc_t mk(logic [6:0] root, logic [15:0] n, string bits, string exp,
                               bit err, int cons, int lat, int sidx, int slen, int flen);
        tc_t t;
        t.root = root; t.n = n; t.bits = bits; t.exp = exp; t.exp_err = err;
        t.exp_cons = cons; t.lat = lat; t.stall_idx = sidx; t.stall_len = slen;
        t.first_len = flen;
        return t;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        bit take_bit;
        @(negedge clk);
        cyc++;
        take_bit = bus.bit_valid && bus.bit_ready;
        if (take_bit) consumed++;
        if (bus.bit_ready) br_seen++;
        if (bus.htree_req) begin
            reqs++;
            if (first_req_cyc < 0) first_req_cyc = cyc;
            pend_act = 1'b1;
            pend = cur_lat;
        end
        if (bus.char_valid) begin
            valid_seen++;
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.char_ready) begin
                if (expq.size() == 0) chk("unexpected_char", 1, 0);
                else chk("char", bus.char_out, expq.pop_front());
                accepted++;
            end else begin
                if (expq.size() > 0) chk("held_char", bus.char_out, expq[0]);
                chk("bit_ready_in_stall", bus.bit_ready, 0);
                held++;
                if (stall_left > 0) stall_left--;
            end
        end
        @(posedge clk); #1;
        if (take_bit && bq.size() > 0) void'(bq.pop_front());
        bus.bit_valid = (bq.size() > 0);
        bus.bit_in    = (bq.size() > 0) ? bq[0] : 1'b0;
        bus.h_valid   = 1'b0;
        if (pend_act) begin
            pend--;
            if (pend <= 0) begin
                bus.h_valid   = 1'b1;
                bus.h_element = mem[bus.htree_index];
                pend_act      = 1'b0;
            end
        end
        bus.char_ready = !hold_ready && !(accepted == stall_idx && stall_left > 0);
    endtask

    task automatic launch(int i);
        cur_lat = tc[i].lat;
        bq.delete();
        for (int k = 0; k < tc[i].bits.len(); k++) bq.push_back(tc[i].bits[k] == "1");
        expq.delete();
        for (int k = 0; k < tc[i].exp.len(); k++) expq.push_back(tc[i].exp[k]);
        consumed = 0; accepted = 0; reqs = 0; br_seen = 0; valid_seen = 0; held = 0;
        first_req_cyc = -1; first_valid_cyc = -1;
        stall_idx = tc[i].stall_idx; stall_left = tc[i].stall_len;
        bus.bit_valid  = (bq.size() > 0);
        bus.bit_in     = (bq.size() > 0) ? bq[0] : 1'b0;
        bus.char_ready = !hold_ready && !(accepted == stall_idx && stall_left > 0);
        bus.start      = 1'b1;
        bus.max_index  = tc[i].root;
        bus.num_chars  = tc[i].n;
        step();
        bus.start = 1'b0;
        cyc = 0;
    endtask

    task automatic run_case(int i);
        int n;
        launch(i);
        n = 0;
        while (!(bus.done || bus.error) && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) chk($sformatf("timeout_case%0d", i), n, 0);
        chk($sformatf("error_case%0d", i), bus.error, tc[i].exp_err);
        chk($sformatf("done_case%0d", i), bus.done, !tc[i].exp_err);
        chk($sformatf("busy_case%0d", i), bus.busy, 0);
        chk($sformatf("chars_left_case%0d", i), expq.size(), 0);
        chk($sformatf("bits_consumed_case%0d", i), consumed, tc[i].exp_cons);
        chk($sformatf("stall_held_case%0d", i), held, tc[i].stall_len);
        if (tc[i].exp.len() == 0) chk($sformatf("no_char_valid_case%0d", i), valid_seen, 0);
        if (tc[i].n == 0) begin
            chk("zero_reqs", reqs, 0);
            chk("zero_bit_ready", br_seen, 0);
            chk("zero_done_latency", n, 0);
        end
        if (tc[i].first_len > 0)
            chk($sformatf("first_char_latency_case%0d", i),
                first_valid_cyc - first_req_cyc, 3 * tc[i].first_len);
    endtask

    initial begin
        string zeros;
        int n;
        for (int k = 0; k < 128; k++) mem[k] = '0;
        mem[2] = {9'h041, 9'h101, 46'd0};
        mem[1] = {9'h042, 9'h043, 46'd0};
        mem[0] = {9'h05A, 9'h180, 46'd0};
        mem[3] = {9'h103, 9'h103, 46'd0};
        zeros = "";
        for (int k = 0; k < 128; k++) zeros = {zeros, "0"};

        tc[0] = mk(7'd2, 16'd3, "01011", "ABC", 1'b0, 5,   1, -1, 0,  1);
        tc[1] = mk(7'd2, 16'd3, "01011", "ABC", 1'b0, 5,   1,  1, 10, 1);
        tc[2] = mk(7'd0, 16'd2, "00",    "ZZ",  1'b0, 2,   1, -1, 0,  1);
        tc[3] = mk(7'd0, 16'd2, "1",     "",    1'b1, 1,   1, -1, 0,  0);
        tc[4] = mk(7'd2, 16'd0, "01",    "",    1'b0, 0,   1, -1, 0,  0);
        tc[5] = mk(7'd3, 16'd1, zeros,   "",    1'b1, 128, 1, -1, 0,  0);
        tc[6] = mk(7'd2, 16'd3, "11100", "CBA", 1'b0, 5,   3, -1, 0,  0);

        bus.start = 0; bus.max_index = 0; bus.num_chars = 0; bus.bit_in = 0;
        bus.bit_valid = 0; bus.h_element = '0; bus.h_valid = 0; bus.char_ready = 0;
        hold_ready = 0; pend_act = 0; pend = 0; cur_lat = 1; stall_idx = -1; stall_left = 0;
        cyc = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bit_ready", bus.bit_ready, 0);
        chk("rst_htree_req", bus.htree_req, 0);
        chk("rst_htree_index", bus.htree_index, 0);
        chk("rst_char_out", bus.char_out, 0);
        chk("rst_char_valid", bus.char_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_case(i);

        // reset while a character is pending in EMIT
        hold_ready = 1'b1;
        launch(0);
        n = 0;
        while (!bus.char_valid && n < 100) begin
            step();
            n++;
        end
        chk("valid_before_rst", bus.char_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_char_valid", bus.char_valid, 0);
        chk("mid_rst_char_out", bus.char_out, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_htree_index", bus.htree_index, 0);
        chk("mid_rst_bit_ready", bus.bit_ready, 0);
        pend_act = 1'b0;
        bus.h_valid = 1'b0;
        hold_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_char_valid", bus.char_valid, 0);
            chk("post_rst_busy", bus.busy, 0);
        end
        run_case(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/t05_huffman_decoder.md
# t05_huffman_decoder

Decompression-side counterpart to the codebook synthesis stage. It consumes a serial Huffman-coded bitstream and walks the same htree in SRAM from the root (`max_index`): bit 0 selects `least1`, bit 1 selects `least2`. Each time it reaches a character leaf it emits that byte over a valid/ready handshake. It sits between the SPI bit source and the output byte sink, and shares the htree SRAM read port with the controller.

## Interface
- Parameters: none. Fixed widths: node index 7 b, htree element 64 b, depth limit 127.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: one-cycle pulse; accepted only in IDLE or DONE/ERROR.
- `max_index` in 7: root node index; latched on `start`.
- `num_chars` in 16: number of characters to decode; latched on `start`.
- `bit_in` in 1: next coded bit.
- `bit_valid` in 1: `bit_in` is valid.
- `bit_ready` out 1: decoder consumes a bit when `bit_valid` and `bit_ready` are both high.
- `htree_req` out 1: one-cycle read request to SRAM.
- `htree_index` out 7: node address; held stable from the request until `h_valid`.
- `h_element` in 64: node data. `least1 = [63:55]`, `least2 = [54:46]`.
- `h_valid` in 1: `h_element` is valid. Arrives ≥1 cycle after `htree_req`.
- `char_out` out 8: decoded character.
- `char_valid` out 1: `char_out` is valid; held until `char_ready`.
- `char_ready` in 1: sink accepts the character.
- `busy` out 1: high in every state except IDLE, DONE and ERROR.
- `done` out 1: level, high in DONE.
- `error` out 1: level, high in ERROR.

## Operation
- Child encoding (9 b):
  - `[8]=1`: sum node; `[6:0]` is the next node index.
  - `[8]=0`: character leaf; `[7:0]` is the character.
  - `9'h180`: null child.
- States: IDLE, FETCH, WAIT_NODE, WAIT_BIT, EMIT, DONE, ERROR.
- IDLE/DONE/ERROR, on `start`:
  - Latch `root = max_index` and `remaining = num_chars`; clear `depth`; set `node = root`.
  - If `num_chars == 0`, go to DONE; otherwise go to FETCH.
- FETCH: assert `htree_req` with `htree_index = node` for one cycle, then go to WAIT_NODE.
- WAIT_NODE: wait for `h_valid`; latch `least1` and `least2` into registers; go to WAIT_BIT.
- WAIT_BIT: assert `bit_ready`. On a consumed bit:
  - Select `child = bit_in ? least2 : least1`, and do `depth = depth + 1`.
  - Null child → ERROR.
  - Leaf → `char_out = child[7:0]`, go to EMIT.
  - Sum → `node = child[6:0]`, go to FETCH.
  - If `depth` would exceed 127 → ERROR, regardless of child type.
- EMIT: hold `char_valid` and `char_out` until `char_ready`. On acceptance:
  - `remaining = remaining - 1` and `depth = 0`.
  - If `remaining` was 1, go to DONE; otherwise set `node = root` and go to FETCH.
- Single-character tree: root `least1` is a character and `least2` is null. Bit 0 emits the character; bit 1 → ERROR.
- `start` in any busy state is ignored.
- `bit_ready` is 0 outside WAIT_BIT. Bits presented at other times are not consumed.
- ERROR is sticky until `start` or `rst`.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE.
  - All outputs 0, including `htree_index` and `char_out`.
  - Internal registers 0.
- Reset mid-operation aborts the decode. A pending `char_valid` drops immediately, and no partial character is later emitted.
- Per coded bit: FETCH 1 cycle + WAIT_NODE ≥1 cycle + WAIT_BIT ≥1 cycle. Minimum is 3 cycles per bit with zero-wait SRAM and bitstream.
- Character emission: `char_valid` rises the cycle after the final bit is consumed; minimum 1 cycle in EMIT.
- Code of length L with zero stalls: `char_valid` first high 3L cycles after the first FETCH.
- `h_valid` asserted in the same cycle as `htree_req` is ignored; only WAIT_NODE samples it.
- `done` rises the cycle after the last `char_ready` handshake.
- `error` rises the cycle after the offending bit is consumed.

## Test plan
Test tree: node 2 = {`least1` = 'A' (`9'h041`), `least2` = sum idx 1 (`9'h101`)}; node 1 = {'B' `9'h042`, 'C' `9'h043`}. `max_index = 2`.
- Basic decode: `num_chars = 3`, bits 0,1,0,1,1, SRAM responds 1 cycle after request, sink always ready → `char_out` A, B, C in order; `done = 1` after the third handshake; exactly 5 bits consumed.
- Backpressure: same stream with `char_ready` held low 10 cycles on 'B' → `char_valid` and 'B' held stable for 10 cycles; `bit_ready` stays 0 during the stall; no bit is lost.
- Single-char tree: node 0 = {'Z' `9'h05A`, null `9'h180`}, `max_index = 0`, `num_chars = 2`, bits 0,0 → Z, Z, then `done`. Separate run with bit 1 → `error = 1` and no `char_valid`.
- Zero count: `num_chars = 0` with `start` → `done` the next cycle; no `htree_req`; `bit_ready` never asserted.
- Depth guard: node 3 = {sum idx 3, sum idx 3} (self loop), 128 bits of 0 → `error` after the 128th consumed bit; `busy = 0`.
- Reset mid-EMIT: assert `rst` while `char_valid = 1` → all outputs 0 immediately. A subsequent `start` then decodes a fresh stream correctly from the root.
